// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing from a 50 MHz clock: pixel-rate counters, raw sync/visibility,
// a tick-advanced delay line matching the drawing pipeline, and registered pin outputs.
module vga_sync_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [11:0] pixel_color,
  output logic [9:0]  X_pix,
  output logic [9:0]  Y_pix,
  output logic        H_visible,
  output logic        V_visible,
  output logic        pixel_clk,
  output logic        frame_start,
  output logic [3:0]  VGA_BUS_R,
  output logic [3:0]  VGA_BUS_G,
  output logic [3:0]  VGA_BUS_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  // Delay-line reset fill: blanked, both syncs inactive.
  localparam logic [2:0] DLY_RESET = 3'b011;

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
      $error("vga_sync_gen: line or frame total does not fit the 10-bit counters");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_delay
      $error("vga_sync_gen: PIPE_DELAY must be within 1..4");
    end
  endgenerate

  logic        pclk_reg;
  logic        frame_start_reg;
  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic        tick;
  logic        x_wrap;
  logic        y_wrap;
  logic        hs_raw;
  logic        vs_raw;
  logic [2:0]  raw_bits;
  logic [2:0]  tap;
  logic        hs_reg;
  logic        vs_reg;
  logic [11:0] rgb_reg;

  // A tick is the edge on which pixel_clk falls, so coordinates are stable at its rising edge.
  assign tick   = pclk_reg;
  assign x_wrap = (x_reg == 10'(H_TOT - 1));
  assign y_wrap = (y_reg == 10'(V_TOT - 1));

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      pclk_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
    end else begin
      pclk_reg        <= ~pclk_reg;
      frame_start_reg <= tick && x_wrap && y_wrap;
      if (tick) begin
        if (x_wrap) begin
          x_reg <= '0;
          y_reg <= y_wrap ? 10'd0 : y_reg + 10'd1;
        end else begin
          x_reg <= x_reg + 10'd1;
        end
      end
    end
  end

  assign H_visible = (x_reg < 10'(H_VIS));
  assign V_visible = (y_reg < 10'(V_VIS));
  assign hs_raw    = !((x_reg >= 10'(H_VIS + H_FP)) && (x_reg <= 10'(H_VIS + H_FP + H_SYNC - 1)));
  assign vs_raw    = !((y_reg >= 10'(V_VIS + V_FP)) && (y_reg <= 10'(V_VIS + V_FP + V_SYNC - 1)));
  assign raw_bits  = {H_visible & V_visible, hs_raw, vs_raw};

  // The output register is the last of the PIPE_DELAY stages, so only PIPE_DELAY-1 live here.
  generate
    if (PIPE_DELAY <= 1) begin : g_no_dly
      assign tap = raw_bits;
    end else begin : g_dly
      logic [2:0] dly_reg [PIPE_DELAY-1];
      always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY - 1; i++) dly_reg[i] <= DLY_RESET;
        end else if (tick) begin
          dly_reg[0] <= raw_bits;
          for (int i = 1; i < PIPE_DELAY - 1; i++) dly_reg[i] <= dly_reg[i-1];
        end
      end
      assign tap = dly_reg[PIPE_DELAY-2];
    end
  endgenerate

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      hs_reg  <= 1'b1;
      vs_reg  <= 1'b1;
      rgb_reg <= '0;
    end else if (tick) begin
      hs_reg  <= tap[1];
      vs_reg  <= tap[0];
      rgb_reg <= tap[2] ? pixel_color : 12'h000;
    end
  end

  assign X_pix       = x_reg;
  assign Y_pix       = y_reg;
  assign pixel_clk   = pclk_reg;
  assign frame_start = frame_start_reg;
  assign VGA_BUS_B   = rgb_reg[11:8];
  assign VGA_BUS_G   = rgb_reg[7:4];
  assign VGA_BUS_R   = rgb_reg[3:0];
  assign VGA_HS      = hs_reg;
  assign VGA_VS      = vs_reg;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Display-timing end of the pixel interface: 640x480 at 60 Hz VGA timing from the 50 MHz board clock.
- Produces the pixel clock, the current coordinates (X_pix, Y_pix) and the visibility flags.
- Accepts the 12-bit pixel_color computed from those coordinates by the drawing logic.
- Drives the DE0 VGA pins with sync and blanking aligned to the drawing pipeline's latency.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DELAY, 2, pixel ticks between a coordinate being presented and its pixel_color being valid (1..4)

Ports:
clk_50  in  1  50 MHz clock
rst  in  1  asynchronous active-high reset
pixel_color  in  12  [11:8] blue, [7:4] green, [3:0] red
X_pix  out  10  horizontal count, 0..799
Y_pix  out  10  vertical count, 0..524
H_visible  out  1  high when X_pix < H_VIS
V_visible  out  1  high when Y_pix < V_VIS
pixel_clk  out  1  clk_50 divided by 2 (25 MHz)
frame_start  out  1  one-clk_50 pulse when counters wrap to (0,0)
VGA_BUS_R  out  4  red
VGA_BUS_G  out  4  green
VGA_BUS_B  out  4  blue
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low

Behaviour:
- Reset (async): pixel_clk=0; X_pix=0; Y_pix=0; H_visible=1; V_visible=1; frame_start=0; RGB=0; VGA_HS=1; VGA_VS=1.
- Reset also fills the delay line with visible=0, HS=1, VS=1.
- Timing is all clk_50 flops. pixel_clk toggles on every clk_50 edge.
- Tick: the clk_50 edge where pixel_clk goes 1->0. Consequence: coordinates are stable at every pixel_clk rising edge.
- On each tick:
  - X_pix increments; at H_VIS+H_FP+H_SYNC+H_BP-1 (799) it wraps to 0 and Y_pix increments.
  - Y_pix wraps from 524 to 0 when X_pix wraps.
- H_visible and V_visible are combinational from the counters.
- Raw sync is low when:
  - HS: X_pix in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
  - VS: Y_pix in [490, 491]. VS is whole-line aligned and changes only when X_pix wraps.
- Delay line: a 3-bit shift register of {visible = H_visible & V_visible, HS_raw, VS_raw}, PIPE_DELAY stages, advancing on ticks only.
- Output stage, registered on each tick:
  - VGA_HS and VGA_VS load the delayed sync bits.
  - If the delayed visible bit is set, RGB loads the pixel_color fields; otherwise RGB loads 0. Blanking must be forced even when pixel_color is nonzero.
- Alignment: RGB at tick t shows the pixel_color for the coordinates presented at tick t-PIPE_DELAY.
- frame_start is high for exactly one clk_50 cycle, on the tick where (X_pix,Y_pix) becomes (0,0). It is not asserted out of reset.
- Width: counters are 10-bit. Totals exceed 1024 only by misconfiguration; flag this with an elaboration-time check.
- No back-pressure: pixel_color is sampled unconditionally on ticks.
- Reset mid-frame: all outputs return to reset values immediately. Counting restarts at (0,0) on the first tick after release.

Test Plan:
- Reset values: assert rst mid-line -> immediately pixel_clk=0, X/Y=0, RGB=0, HS=VS=1; after release, first tick -> X_pix=1.
- Line timing: run 2 lines -> HS low for exactly 96 ticks, falling 656+PIPE_DELAY ticks after X_pix=0; line period 800 ticks = 1600 clk_50.
- Frame timing: frame_start spacing = 840000 clk_50. VS low for 1600 ticks starting at Y_pix=490 (+2 ticks delay).
- Blanking: pixel_color=12'hFFF constant -> RGB=F,F,F only while the delayed visible bit is set. RGB=0 at delayed X 640..799 and at Y 480..524.
- Alignment: drive pixel_color from a 2-stage registered model of X_pix[3:0] -> VGA_BUS_R equals the X[3:0] of the displayed pixel on every visible tick.
- PIPE_DELAY=1 rebuild: same alignment check with a 1-stage model. Sync edges shift one tick earlier.
